hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit that owns the HI/LO register pair of the multicycle CPU core.
//  Replaces single-cycle '*', '/' and '%' in Execute with a WIDTH-parametrised, signed/unsigned, radix-2 datapath.
//  Stalls the core through a valid/ready handshake and busy.
//  The core issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH   32   operand, HI and LO width in bits (>=4)
//  CNT_W   $clog2(WIDTH)+1   iteration-counter width (derived, do not override)
// PORTS
//  clk          in   1      clock; all state changes on posedge
//  reset        in   1      synchronous, active-high reset
//  start_valid  in   1      core requests an operation this cycle
//  start_ready  out  1      unit can accept; equals !busy
//  op           in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
//  operand_a    in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
//  operand_b    in   WIDTH  rt value (multiplier / divisor)
//  hi           out  WIDTH  HI register
//  lo           out  WIDTH  LO register
//  busy         out  1      iterative op in flight
//  done         out  1      one-cycle pulse when an accepted op has committed
//  div_zero     out  1      one-cycle pulse with done when DIV/DIVU had operand_b==0
// BEHAVIOUR
//  Reset (one clk, reset=1): hi=lo=0, busy=0, done=0, div_zero=0, state=IDLE, counter=0.
//   Reset aborts any op in flight; the partial result is discarded.
//  Accept: start_valid && start_ready at posedge E0. operands and op are latched at E0.
//   Inputs are don't-care afterwards. start_valid while busy is ignored, not queued.
//  States: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
//  MTHI/MTLO: no RUN; hi (or lo) = operand_a at E0; done=1 for the cycle after E0; busy stays 0.
//  Reserved op: accepted; no register change; done pulses after E0.
//  DIV/DIVU with operand_b==0: no RUN. At E0: lo={WIDTH{1'b1}}, hi=operand_a; done=div_zero=1 for one cycle.
//  MULT/MULTU/DIV/DIVU (b!=0): busy=1 from E0. One iteration per edge E1..E_WIDTH. FIX at E_(WIDTH+1).
//   At FIX: hi/lo commit, done=1 and busy=0 for the following cycle. Earliest next accept is E_(WIDTH+2).
//   Latency is identical for signed and unsigned ops.
//  hi/lo keep their old values throughout RUN; the only writes are at FIX, MTHI/MTLO and div-by-zero.
//  Signed ops: magnitudes latched at E0 with sign flags; unsigned datapath in RUN; sign fix applied in FIX.
//  MULT(U): shift-add into a 2*WIDTH accumulator. {hi,lo} = full 2*WIDTH product.
//   Signed product is negated in FIX if the operand signs differ.
//  DIV(U): restoring division; lo=quotient, hi=remainder.
//   Signed: quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
//   Signed overflow MIN/-1: lo=MIN (e.g. 0x80000000), hi=0, no flag.
//  |MIN| = 2^(WIDTH-1) must be held unsigned in the datapath without loss.
//  done and div_zero are never asserted outside the cases above; both are 0 during RUN.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//    busy high 33 cycles; done exactly 33 cycles after accept.
//  2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB.
//    MULT a=0x80000000 b=0x80000000 -> hi=0x40000000 lo=0.
//  3 DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//    DIVU a=7 b=2 -> lo=3 hi=1.
//    DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 DIVU a=5 b=0 -> next cycle done=div_zero=1, lo=0xFFFFFFFF hi=5, busy never set.
//  5 MTHI 0x1234 during a busy MULT -> start_ready=0 and op dropped; hi changes only at FIX.
//    MTLO 0xABCD when idle -> lo=0xABCD one cycle later, with done.
//  6 reset asserted 10 cycles into a DIV -> next cycle hi=lo=0, busy=0, no done.
//    A following MULTU 6*7 gives lo=42.
//    Repeat 1-3 with WIDTH=8 (e.g. MULT -3*7 -> hi=0xFF lo=0xEB).

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
// Latency: MULT/DIV commit WIDTH+1 cycles after accept; MTHI/MTLO/div-by-zero/reserved commit at accept.
// Backpressure: start_ready drops while an iterative op runs; requests made then are dropped, not queued.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc holds {accumulator, multiplier} for MULT and {remainder, quotient} for DIV
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // multiplicand magnitude for MULT, divisor magnitude for DIV
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;          // negate product / quotient in FIX
    logic               rem_neg_q, rem_neg_d;  // remainder follows the dividend sign
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    // Signed ops work on magnitudes; |MIN| wraps to itself, which is exact as an unsigned value
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & operand_a[WIDTH-1];
    assign b_neg     = is_signed & operand_b[WIDTH-1];
    assign a_mag     = a_neg ? (-operand_a) : operand_a;
    assign b_mag     = b_neg ? (-operand_b) : operand_b;

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right with carry
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit into the remainder, subtract divisor when it fits
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opd_q};
    assign div_ge   = (div_sh >= {1'b0, opd_q});
    assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    // Sign-corrected results committed in FIX
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_q ? (-acc_q) : acc_q;
    assign quo_fix  = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    // Next state: decode and latch in IDLE, one iteration per RUN cycle, sign fix and commit in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    done_d = 1'b1;
                    case (op)
                        3'b000, 3'b001: begin
                            state_d   = S_RUN;
                            cnt_d     = '0;
                            is_div_d  = 1'b0;
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opd_d     = a_mag;
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = 1'b0;
                            done_d    = 1'b0;
                        end
                        3'b010, 3'b011: begin
                            if (operand_b == '0) begin
                                lo_d = '1;
                                hi_d = operand_a;
                                dz_d = 1'b1;
                            end else begin
                                state_d   = S_RUN;
                                cnt_d     = '0;
                                is_div_d  = 1'b1;
                                acc_d     = {{WIDTH{1'b0}}, a_mag};
                                opd_d     = b_mag;
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                                done_d    = 1'b0;
                            end
                        end
                        3'b100:  hi_d = operand_a;
                        3'b101:  lo_d = operand_a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = ~start_ready;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_zero    = dz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: a WIDTH=32 and a WIDTH=8 instance share stimulus, selected by sel.
// Expected HI/LO/div_zero/latency come from an arithmetic model and are queued at issue time.
// The bench drives inputs on negedge and samples outputs 1ns after posedge.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_valid;
    logic        sel;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b;

    logic        sv32, sv8;
    logic        rdy32, busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        rdy8, busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    assign sv32 = start_valid & ~sel;
    assign sv8  = start_valid & sel;

    hilo_muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .start_valid(sv32), .start_ready(rdy32), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .hi(hi32), .lo(lo32),
        .busy(busy32), .done(done32), .div_zero(dz32)
    );

    hilo_muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start_valid(sv8), .start_ready(rdy8), .op(op),
        .operand_a(operand_a[7:0]), .operand_b(operand_b[7:0]), .hi(hi8), .lo(lo8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    logic [31:0] cur_hi, cur_lo;
    logic        cur_rdy, cur_busy, cur_done, cur_dz;
    int          cur_w;
    assign cur_hi   = sel ? {24'd0, hi8} : hi32;
    assign cur_lo   = sel ? {24'd0, lo8} : lo32;
    assign cur_rdy  = sel ? rdy8 : rdy32;
    assign cur_busy = sel ? busy8 : busy32;
    assign cur_done = sel ? done8 : done32;
    assign cur_dz   = sel ? dz8 : dz32;
    assign cur_w    = sel ? 8 : 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sh_hi, sh_lo;
    int          checks = 0;
    int          errors = 0;

    // Reference arithmetic in 64-bit integers, truncated to w bits
    function automatic void model(input int w, input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] eh,
                                  inout logic [31:0] el, output logic edz, output int lat);
        longint      ua, ub, sa, sb_v, q, r;
        logic [63:0] p, mask;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a & mask[31:0]};
        ub   = {32'd0, b & mask[31:0]};
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb_v = ub[w-1] ? ub - (longint'(1) << w) : ub;
        edz  = 1'b0;
        lat  = 0;
        case (o)
            3'd0, 3'd1: begin
                p   = (o == 3'd0) ? 64'(sa * sb_v) : 64'(ua * ub);
                eh  = 32'((p >> w) & mask);
                el  = 32'(p & mask);
                lat = w + 1;
            end
            3'd2, 3'd3: begin
                if (ub == 0) begin
                    el  = mask[31:0];
                    eh  = ua[31:0];
                    edz = 1'b1;
                end else begin
                    if (o == 3'd2) begin
                        q = sa / sb_v;
                        r = sa % sb_v;
                    end else begin
                        q = ua / ub;
                        r = ua % ub;
                    end
                    el  = 32'(64'(q) & mask);
                    eh  = 32'(64'(r) & mask);
                    lat = w + 1;
                end
            end
            3'd4:    eh = ua[31:0];
            3'd5:    el = ua[31:0];
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!cur_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cur_rdy !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: start_ready=%0b required 1", cur_rdy);
        end
        start_valid = 1'b1;
        op          = o;
        operand_a   = a;
        operand_b   = b;
        e.old_hi    = sh_hi;
        e.old_lo    = sh_lo;
        model(cur_w, o, a, b, sh_hi, sh_lo, e.dz, e.lat);
        e.hi = sh_hi;
        e.lo = sh_lo;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op          = 3'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
    endtask

    // Called 1ns after the accepting edge: pop the oldest expectation and follow the op to its commit
    task automatic sb_wait_commit(input string name);
        exp_t e;
        int   n, busy_n;
        logic stray, held;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s sb_empty: entries=0 required >0", name);
            return;
        end
        e      = sb.pop_front();
        n      = 0;
        busy_n = 0;
        stray  = 1'b0;
        held   = 1'b1;
        while (!cur_done && n < 200) begin
            if (cur_busy) busy_n++;
            if (cur_dz) stray = 1'b1;
            if (cur_hi !== e.old_hi || cur_lo !== e.old_lo) held = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (cur_done !== 1'b1 || n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: done=%0b after %0d cycles required %0d", name, cur_done, n, e.lat);
        end
        checks++;
        if (busy_n !== e.lat) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_n, e.lat);
        end
        checks++;
        if (cur_hi !== e.hi || cur_lo !== e.lo) begin
            errors++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, cur_hi, cur_lo, e.hi, e.lo);
        end
        checks++;
        if (cur_dz !== e.dz || stray) begin
            errors++;
            $display("FAIL %s div_zero: got %0b stray=%0b required %0b", name, cur_dz, stray, e.dz);
        end
        checks++;
        if (!held || cur_busy !== 1'b0 || cur_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold_idle: held=%0b busy=%0b ready=%0b required 1/0/1", name, held, cur_busy, cur_rdy);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        sh_hi = '0;
        sh_lo = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cur_hi !== 0 || cur_lo !== 0 || cur_busy !== 0 || cur_done !== 0 || cur_dz !== 0 || cur_rdy !== 1) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%0b done=%0b dz=%0b rdy=%0b required 0/0/0/0/0/1",
                     cur_hi, cur_lo, cur_busy, cur_done, cur_dz, cur_rdy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Spec vectors for the 32-bit instance, with hand-derived results
    task automatic test_mul_div32();
        logic [2:0]  t_op[6] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd2};
        logic [31:0] t_a[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] t_b[6]  = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] t_hi[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd1, 32'd0};
        logic [31:0] t_lo[6] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFD, 32'd3, 32'h80000000};
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            sb_wait_commit("vec32");
            checks++;
            if (cur_hi !== t_hi[i] || cur_lo !== t_lo[i]) begin
                errors++;
                $display("FAIL vec32_%0d: hi=%h lo=%h required hi=%h lo=%h", i, cur_hi, cur_lo, t_hi[i], t_lo[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (cur_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%0b required 0", cur_done);
        end
    endtask

    task automatic test_div_zero();
        issue(3'd3, 32'd5, 32'd0);
        sb_wait_commit("divu_zero");
        checks++;
        if (cur_hi !== 32'd5 || cur_lo !== 32'hFFFFFFFF || cur_dz !== 1'b1) begin
            errors++;
            $display("FAIL divu_zero_vals: hi=%h lo=%h dz=%0b required 5/ffffffff/1", cur_hi, cur_lo, cur_dz);
        end
        issue(3'd2, 32'h80000000, 32'd0);
        sb_wait_commit("div_zero_signed");
    endtask

    task automatic test_mt_while_busy();
        logic rdy_low, hi_held;
        issue(3'd0, 32'd123456, 32'hFFFFFCEB);
        rdy_low = 1'b1;
        hi_held = 1'b1;
        fork
            sb_wait_commit("mult_under_mthi");
            begin
                repeat (5) begin
                    @(negedge clk);
                    start_valid = 1'b1;
                    op          = 3'd4;
                    operand_a   = 32'h1234;
                    if (cur_rdy !== 1'b0) rdy_low = 1'b0;
                    if (cur_hi === 32'h1234) hi_held = 1'b0;
                end
                @(negedge clk);
                start_valid = 1'b0;
            end
        join
        checks++;
        if (!rdy_low || !hi_held) begin
            errors++;
            $display("FAIL mthi_dropped_busy: ready_low=%0b hi_held=%0b required 1/1", rdy_low, hi_held);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cur_hi !== sh_hi || cur_done !== 1'b0) begin
            errors++;
            $display("FAIL mthi_not_queued: hi=%h done=%0b required hi=%h done=0", cur_hi, cur_done, sh_hi);
        end
        issue(3'd5, 32'hABCD, 32'd0);
        sb_wait_commit("mtlo_idle");
        checks++;
        if (cur_lo !== 32'hABCD) begin
            errors++;
            $display("FAIL mtlo_value: lo=%h required 0000abcd", cur_lo);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        issue(3'd2, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cur_hi !== 0 || cur_lo !== 0 || cur_busy !== 0 || cur_done !== 0) begin
            errors++;
            $display("FAIL reset_abort: hi=%h lo=%h busy=%0b done=%0b required 0/0/0/0", cur_hi, cur_lo, cur_busy, cur_done);
        end
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        sh_hi    = '0;
        sh_lo    = '0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (cur_done !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_abort_no_done: done seen=1 required 0");
        end
        issue(3'd1, 32'd6, 32'd7);
        sb_wait_commit("multu_after_reset");
        checks++;
        if (cur_lo !== 32'd42 || cur_hi !== 32'd0) begin
            errors++;
            $display("FAIL multu_6x7: hi=%h lo=%h required 0/42", cur_hi, cur_lo);
        end
    endtask

    task automatic test_back_to_back(input int count);
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < count; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h80000000 >> (32 - cur_w);
            issue(o, a, b);
            sb_wait_commit("random");
        end
    endtask

    task automatic test_width8();
        logic [2:0]  t_op[6] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd2};
        logic [31:0] t_a[6]  = '{32'hFF, 32'hFD, 32'h80, 32'hF9, 32'd7, 32'h80};
        logic [31:0] t_b[6]  = '{32'hFF, 32'd7, 32'h80, 32'd2, 32'd2, 32'hFF};
        logic [31:0] t_hi[6] = '{32'hFE, 32'hFF, 32'h40, 32'hFF, 32'd1, 32'd0};
        logic [31:0] t_lo[6] = '{32'h01, 32'hEB, 32'h00, 32'hFD, 32'd3, 32'h80};
        sel = 1'b1;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            sb_wait_commit("vec8");
            checks++;
            if (cur_hi !== t_hi[i] || cur_lo !== t_lo[i]) begin
                errors++;
                $display("FAIL vec8_%0d: hi=%h lo=%h required hi=%h lo=%h", i, cur_hi, cur_lo, t_hi[i], t_lo[i]);
            end
        end
        test_back_to_back(12);
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        sel         = 1'b0;
        op          = 3'd0;
        operand_a   = '0;
        operand_b   = '0;
        sh_hi       = '0;
        sh_lo       = '0;
        test_reset();
        test_mul_div32();
        test_div_zero();
        test_mt_while_busy();
        test_reset_abort();
        test_back_to_back(20);
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
